ram_access_control: RTL and testbench

Parametrised DRAM access sequencer for the VG8020 main-RAM path, replacing the purely combinational write-enable decode with a clocked /RAS–/CAS–/WE generator. It samples the Z80 memory strobes (/MREQ, /RD, /WR, /RFSH), multiplexes the CPU address into row and column halves, and drives per-bank /RAS, shared /CAS and /WE. It also performs RAS-only refresh during Z80 refresh cycles. It sits between the CPU bus interface and the DRAM array.

---
 rtl/ram_access_control.sv | 143 ++++++++++++++
 tb/tb_ram_access_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_access_control.sv
// ram_access_control: clocked /RAS-/CAS-/WE sequencer with RAS-only refresh for the Z80 main-RAM path.
module ram_access_control #(
  parameter int BANKS = 2,
  parameter int ROW_BITS = 8,
  parameter int RAS_CAS_CYCLES = 1,
  parameter int CAS_CYCLES = 2,
  parameter int PRECHARGE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic nmreq,
  input  logic nrd,
  input  logic nwr,
  input  logic nrfsh,
  input  logic [2*ROW_BITS-1:0] addr,
  input  logic [(BANKS > 1 ? $clog2(BANKS) : 1)-1:0] bank,
  output logic [BANKS-1:0] nras,
  output logic ncas,
  output logic nwe,
  output logic [ROW_BITS-1:0] ma,
  output logic busy
);
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
  localparam int M1 = RAS_CAS_CYCLES > CAS_CYCLES ? RAS_CAS_CYCLES : CAS_CYCLES;
  localparam int MC = M1 > PRECHARGE_CYCLES ? M1 : PRECHARGE_CYCLES;
  localparam int CW = $clog2(MC) + 1;
  localparam logic [BW:0] NB = BANKS[BW:0];
  typedef enum logic [2:0] {IDLE, RAS, CAS, HOLD, PRE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic nmreq_q, nrd_q, nwr_q, nrfsh_q;
  logic [2*ROW_BITS-1:0] addr_q;
  logic [BW-1:0] bank_q, bnk_q, bnk_d;
  logic [ROW_BITS-1:0] row_q, row_d, col_q, col_d, ma_q, ma_d;
  logic wr_q, wr_d, rf_q, rf_d;
  logic [BANKS-1:0] nras_q, nras_d, sel;
  logic ncas_q, ncas_d, nwe_q, nwe_d, busy_q;
  logic acc, rfsh, last;
  always_comb begin
    acc = !nmreq_q && nrfsh_q && (!nrd_q || !nwr_q) && ({1'b0, bank_q} < NB);
    rfsh = !nmreq_q && !nrfsh_q;
    last = cnt_q == '0;
    state_d = state_q;
    cnt_d = last ? cnt_q : cnt_q - 1'b1;
    row_d = row_q;
    col_d = col_q;
    bnk_d = bnk_q;
    wr_d = wr_q;
    rf_d = rf_q;
    case (state_q)
      IDLE: if (rfsh || acc) begin
        state_d = RAS;
        cnt_d = CW'(RAS_CAS_CYCLES - 1);
        row_d = addr_q[2*ROW_BITS-1:ROW_BITS];
        col_d = addr_q[ROW_BITS-1:0];
        bnk_d = bank_q;
        rf_d = rfsh;
        wr_d = acc && !nwr_q && nrd_q;
      end
      RAS: if (nmreq_q) begin
        state_d = PRE;
        cnt_d = CW'(PRECHARGE_CYCLES - 1);
      end else if (last) begin
        state_d = rf_q ? HOLD : CAS;
        cnt_d = rf_q ? '0 : CW'(CAS_CYCLES - 1);
      end
      CAS: if (nmreq_q) begin
        state_d = PRE;
        cnt_d = CW'(PRECHARGE_CYCLES - 1);
      end else if (last) state_d = HOLD;
      HOLD: if (nmreq_q) begin
        state_d = PRE;
        cnt_d = CW'(PRECHARGE_CYCLES - 1);
      end
      PRE: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so every strobe leaves a flop on the transition edge.
    sel = BANKS'(1) << bnk_d;
    nras_d = '1;
    ncas_d = 1'b1;
    nwe_d = 1'b1;
    ma_d = addr_q[2*ROW_BITS-1:ROW_BITS];
    case (state_d)
      RAS: begin
        nras_d = rf_d ? '0 : ~sel;
        ma_d = row_d;
      end
      CAS: begin
        nras_d = ~sel;
        ncas_d = 1'b0;
        nwe_d = !wr_d;
        ma_d = col_d;
      end
      HOLD: begin
        nras_d = nras_q;
        ncas_d = ncas_q;
        nwe_d = nwe_q;
        ma_d = ma_q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {nmreq_q, nrd_q, nwr_q, nrfsh_q} <= '1;
      addr_q <= '0;
      bank_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      bnk_q <= '0;
      wr_q <= 1'b0;
      rf_q <= 1'b0;
      nras_q <= '1;
      ncas_q <= 1'b1;
      nwe_q <= 1'b1;
      ma_q <= '0;
      busy_q <= 1'b0;
    end else begin
      {nmreq_q, nrd_q, nwr_q, nrfsh_q} <= {nmreq, nrd, nwr, nrfsh};
      addr_q <= addr;
      bank_q <= bank;
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
      bnk_q <= bnk_d;
      wr_q <= wr_d;
      rf_q <= rf_d;
      nras_q <= nras_d;
      ncas_q <= ncas_d;
      nwe_q <= nwe_d;
      ma_q <= ma_d;
      busy_q <= state_d != IDLE;
    end
  assign nras = nras_q;
  assign ncas = ncas_q;
  assign nwe = nwe_q;
  assign ma = ma_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ram_access_control.sv
// tb_ram_access_control: cycle traces from tables through a scoreboard, plus reset and bank corner sequences.
module tb_ram_access_control;
  logic clk = 1'b0, reset = 1'b0, nmreq = 1'b1, nrd = 1'b1, nwr = 1'b1, nrfsh = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [0:0] bank = 1'b0, bank2 = 1'b1;
  logic [1:0] nras;
  logic ncas, nwe, busy;
  logic [7:0] ma;
  logic [0:0] nras2;
  logic ncas2, nwe2, busy2;
  logic [7:0] ma2;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] strb;
    logic [15:0] a;
    logic [0:0] b;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [12:0] sb[$];
  int sbi[$];
  localparam logic [3:0] IDL = 4'b1111, RD = 4'b0011, WR = 4'b0101, RF = 4'b0110, BOTH = 4'b0001, MQ = 4'b0111;

  always #5 clk = ~clk;

  ram_access_control dut (
    .clk(clk), .reset(reset), .nmreq(nmreq), .nrd(nrd), .nwr(nwr), .nrfsh(nrfsh),
    .addr(addr), .bank(bank), .nras(nras), .ncas(ncas), .nwe(nwe), .ma(ma), .busy(busy)
  );

  ram_access_control #(.BANKS(1)) dut2 (
    .clk(clk), .reset(reset), .nmreq(nmreq), .nrd(nrd), .nwr(nwr), .nrfsh(nrfsh),
    .addr(addr), .bank(bank2), .nras(nras2), .ncas(ncas2), .nwe(nwe2), .ma(ma2), .busy(busy2)
  );

  function automatic void add(logic [3:0] s, logic [15:0] a, logic [0:0] b, logic [1:0] r,
                              logic [1:0] cw, logic [7:0] m, logic bz);
    tbl.push_back('{s, a, b, {r, cw, m, bz}});
  endfunction

  task automatic check(string nm, logic [12:0] got, logic [12:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic run_table(string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) check($sformatf("%s[%0d]", nm, sbi.pop_front()), {nras, ncas, nwe, ma, busy}, sb.pop_front());
      {nmreq, nrd, nwr, nrfsh} = tbl[i].strb;
      addr = tbl[i].a;
      bank = tbl[i].b;
      sb.push_back(tbl[i].exp);
      sbi.push_back(i);
    end
    @(negedge clk);
    check($sformatf("%s[%0d]", nm, sbi.pop_front()), {nras, ncas, nwe, ma, busy}, sb.pop_front());
    tbl.delete();
  endtask

  task automatic do_reset(string nm);
    #2 reset = 1'b1;
    #1 check(nm, {nras, ncas, nwe, ma, busy}, 13'b11_1_1_00000000_0);
    {nmreq, nrd, nwr, nrfsh} = IDL;
    addr = 16'h0000;
    bank = 1'b0;
    bank2 = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset("reset_init");
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'h00, 1'b0);
    add(RD,  16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b0);
    add(RD,  16'hA55A, 1'b1, 2'b01, 2'b11, 8'hA5, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b01, 2'b01, 8'h5A, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b01, 2'b01, 8'h5A, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b01, 2'b01, 8'h5A, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b0);
    run_table("read");
    do_reset("reset_after_read");
    add(IDL, 16'h1234, 1'b0, 2'b11, 2'b11, 8'h00, 1'b0);
    add(WR,  16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b0);
    add(WR,  16'h1234, 1'b0, 2'b10, 2'b11, 8'h12, 1'b1);
    add(WR,  16'h1234, 1'b0, 2'b10, 2'b00, 8'h34, 1'b1);
    add(WR,  16'h1234, 1'b0, 2'b10, 2'b00, 8'h34, 1'b1);
    add(WR,  16'h1234, 1'b0, 2'b10, 2'b00, 8'h34, 1'b1);
    add(IDL, 16'h1234, 1'b0, 2'b10, 2'b00, 8'h34, 1'b1);
    add(IDL, 16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b1);
    add(IDL, 16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b1);
    add(IDL, 16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b0);
    run_table("write");
    do_reset("reset_after_write");
    add(IDL, 16'h7F00, 1'b0, 2'b11, 2'b11, 8'h00, 1'b0);
    add(RF,  16'h7F00, 1'b0, 2'b11, 2'b11, 8'h7F, 1'b0);
    add(RF,  16'h7F00, 1'b0, 2'b00, 2'b11, 8'h7F, 1'b1);
    add(RF,  16'h7F00, 1'b0, 2'b00, 2'b11, 8'h7F, 1'b1);
    add(IDL, 16'h7F00, 1'b0, 2'b00, 2'b11, 8'h7F, 1'b1);
    add(IDL, 16'h7F00, 1'b0, 2'b11, 2'b11, 8'h7F, 1'b1);
    add(IDL, 16'h7F00, 1'b0, 2'b11, 2'b11, 8'h7F, 1'b1);
    add(IDL, 16'h7F00, 1'b0, 2'b11, 2'b11, 8'h7F, 1'b0);
    run_table("refresh");
    do_reset("reset_after_refresh");
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'h00, 1'b0);
    add(RD,  16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b0);
    add(IDL, 16'hA55A, 1'b1, 2'b01, 2'b11, 8'hA5, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b0);
    add(RD,  16'hA55A, 1'b1, 2'b01, 2'b11, 8'hA5, 1'b1);
    add(RD,  16'hA55A, 1'b1, 2'b01, 2'b01, 8'h5A, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b01, 2'b01, 8'h5A, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b1);
    add(IDL, 16'hA55A, 1'b1, 2'b11, 2'b11, 8'hA5, 1'b0);
    run_table("abort_b2b");
    do_reset("reset_after_abort");
    add(IDL,  16'h1234, 1'b0, 2'b11, 2'b11, 8'h00, 1'b0);
    add(BOTH, 16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b0);
    add(BOTH, 16'h1234, 1'b0, 2'b10, 2'b11, 8'h12, 1'b1);
    add(BOTH, 16'h1234, 1'b0, 2'b10, 2'b01, 8'h34, 1'b1);
    add(BOTH, 16'h1234, 1'b0, 2'b10, 2'b01, 8'h34, 1'b1);
    add(IDL,  16'h1234, 1'b0, 2'b10, 2'b01, 8'h34, 1'b1);
    add(IDL,  16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b1);
    add(IDL,  16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b1);
    add(IDL,  16'h1234, 1'b0, 2'b11, 2'b11, 8'h12, 1'b0);
    run_table("rd_wr_both");
    do_reset("reset_after_both");
    add(IDL, 16'h5500, 1'b0, 2'b11, 2'b11, 8'h00, 1'b0);
    add(MQ,  16'h5500, 1'b0, 2'b11, 2'b11, 8'h55, 1'b0);
    add(MQ,  16'h5500, 1'b0, 2'b11, 2'b11, 8'h55, 1'b0);
    add(MQ,  16'h5500, 1'b0, 2'b11, 2'b11, 8'h55, 1'b0);
    run_table("mreq_only");
    do_reset("reset_before_bank");
    bank2 = 1'b1;
    addr = 16'hA55A;
    {nmreq, nrd, nwr, nrfsh} = RD;
    repeat (4) begin
      @(negedge clk);
      check("bad_bank", {9'b0, nras2, ncas2, nwe2, busy2}, 13'b1110);
    end
    bank2 = 1'b0;
    n = 0;
    while (nras2 !== 1'b0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("good_bank_ras", {11'b0, nras2, busy2}, 13'b01);
    do_reset("reset_before_midcas");
    addr = 16'h1234;
    bank = 1'b0;
    {nmreq, nrd, nwr, nrfsh} = WR;
    n = 0;
    while (ncas !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("write_cas", {11'b0, ncas, nwe}, 13'b0);
    do_reset("reset_mid_cas");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
